// File: rtl/cpu_bus_arbiter_pkg.sv
// rtl/cpu_bus_arbiter_pkg.sv - shared types and constants for the CPU bus arbiter
package cpu_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    OWN_A,
    OWN_B,
    SWITCH_A,
    SWITCH_B
  } arb_state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam logic [7:0] COUNT_MAX = 8'hFF;

  // Saturating increment of the per-ownership transaction counter
  function automatic logic [7:0] count_inc(input logic [7:0] value);
    return (value == COUNT_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/cpu_bus_arbiter.sv
// rtl/cpu_bus_arbiter.sv - round-robin two-port arbiter for the system memory bus
module cpu_bus_arbiter
  import cpu_bus_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 8
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_pa_request,
  input  logic        i_pa_rw,
  input  logic [31:0] i_pa_address,
  input  logic [31:0] i_pa_wdata,
  output logic        o_pa_ready,
  output logic [31:0] o_pa_rdata,
  input  logic        i_pb_request,
  input  logic        i_pb_rw,
  input  logic [31:0] i_pb_address,
  input  logic [31:0] i_pb_wdata,
  output logic        o_pb_ready,
  output logic [31:0] o_pb_rdata,
  output logic        o_bus_request,
  output logic        o_bus_rw,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ready,
  input  logic [31:0] i_bus_rdata
);

  // Burst limit widened to 9 bits so count+1 never wraps at 255
  localparam logic [8:0] BURST_LIMIT = 9'(MAX_BURST);

  arb_state_t state, state_d;
  logic       last, last_d;
  logic [7:0] count, count_d;
  logic       burst_done;

  assign burst_done = ({1'b0, count} + 9'd1) >= BURST_LIMIT;

  // Next-state selection and combinational routing of the owner onto the bus
  always_comb begin
    state_d       = state;
    last_d        = last;
    count_d       = count;
    o_bus_request = 1'b0;
    o_bus_rw      = 1'b0;
    o_bus_address = 32'd0;
    o_bus_wdata   = 32'd0;
    o_pa_ready    = 1'b0;
    o_pa_rdata    = 32'd0;
    o_pb_ready    = 1'b0;
    o_pb_rdata    = 32'd0;

    case (state)
      IDLE: begin
        // A wins when alone, or on a tie when B was served last
        if (i_pa_request && (!i_pb_request || last == PORT_B)) begin
          state_d = OWN_A;
          last_d  = PORT_A;
          count_d = 8'd0;
        end else if (i_pb_request) begin
          state_d = OWN_B;
          last_d  = PORT_B;
          count_d = 8'd0;
        end
      end

      OWN_A: begin
        o_bus_request = i_pa_request;
        o_bus_rw      = i_pa_rw;
        o_bus_address = i_pa_address;
        o_bus_wdata   = i_pa_wdata;
        o_pa_ready    = i_bus_ready;
        o_pa_rdata    = i_bus_rdata;
        if (!i_pa_request) begin
          state_d = IDLE;
        end else if (i_bus_ready) begin
          count_d = count_inc(count);
          if (i_pb_request && burst_done) begin
            state_d = SWITCH_B;
          end
        end
      end

      OWN_B: begin
        o_bus_request = i_pb_request;
        o_bus_rw      = i_pb_rw;
        o_bus_address = i_pb_address;
        o_bus_wdata   = i_pb_wdata;
        o_pb_ready    = i_bus_ready;
        o_pb_rdata    = i_bus_rdata;
        if (!i_pb_request) begin
          state_d = IDLE;
        end else if (i_bus_ready) begin
          count_d = count_inc(count);
          if (i_pa_request && burst_done) begin
            state_d = SWITCH_A;
          end
        end
      end

      SWITCH_A: begin
        state_d = OWN_A;
        last_d  = PORT_A;
        count_d = 8'd0;
      end

      SWITCH_B: begin
        state_d = OWN_B;
        last_d  = PORT_B;
        count_d = 8'd0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Reset silences every output immediately, abandoning any transaction
    if (i_reset) begin
      o_bus_request = 1'b0;
      o_bus_rw      = 1'b0;
      o_bus_address = 32'd0;
      o_bus_wdata   = 32'd0;
      o_pa_ready    = 1'b0;
      o_pa_rdata    = 32'd0;
      o_pb_ready    = 1'b0;
      o_pb_rdata    = 32'd0;
    end
  end

  // State, last-granted port and burst counter registers
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= IDLE;
      last  <= PORT_B;
      count <= 8'd0;
    end else begin
      state <= state_d;
      last  <= last_d;
      count <= count_d;
    end
  end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb/tb_cpu_bus_arbiter.sv - directed self-checking bench for cpu_bus_arbiter
module tb_cpu_bus_arbiter;

  logic        i_clock;
  logic        i_reset;
  logic        i_pa_request, i_pa_rw;
  logic [31:0] i_pa_address, i_pa_wdata;
  logic        o_pa_ready;
  logic [31:0] o_pa_rdata;
  logic        i_pb_request, i_pb_rw;
  logic [31:0] i_pb_address, i_pb_wdata;
  logic        o_pb_ready;
  logic [31:0] o_pb_rdata;
  logic        o_bus_request, o_bus_rw;
  logic [31:0] o_bus_address, o_bus_wdata;
  logic        i_bus_ready;
  logic [31:0] i_bus_rdata;

  int errors = 0;
  int checks = 0;

  cpu_bus_arbiter #(.MAX_BURST(2)) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_pa_request (i_pa_request),
    .i_pa_rw      (i_pa_rw),
    .i_pa_address (i_pa_address),
    .i_pa_wdata   (i_pa_wdata),
    .o_pa_ready   (o_pa_ready),
    .o_pa_rdata   (o_pa_rdata),
    .i_pb_request (i_pb_request),
    .i_pb_rw      (i_pb_rw),
    .i_pb_address (i_pb_address),
    .i_pb_wdata   (i_pb_wdata),
    .o_pb_ready   (o_pb_ready),
    .o_pb_rdata   (o_pb_rdata),
    .o_bus_request(o_bus_request),
    .o_bus_rw     (o_bus_rw),
    .o_bus_address(o_bus_address),
    .o_bus_wdata  (o_bus_wdata),
    .i_bus_ready  (i_bus_ready),
    .i_bus_rdata  (i_bus_rdata)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic settle();
    @(negedge i_clock);
  endtask

  task automatic test_reset();
    logic [131:0] outs;
    i_reset = 1'b1;
    i_pa_request = 1'b1; i_pa_rw = 1'b1; i_pa_address = 32'hA0; i_pa_wdata = 32'hAAAA;
    i_pb_request = 1'b1; i_pb_rw = 1'b1; i_pb_address = 32'hB0; i_pb_wdata = 32'hBBBB;
    i_bus_ready = 1'b1; i_bus_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      settle();
      outs = {o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata,
              o_pa_ready, o_pa_rdata, o_pb_ready, o_pb_rdata};
      checks++;
      if (outs !== 132'd0) begin
        errors++; $display("FAIL reset_outputs_zero cycle %0d: got %h expected 0", i, outs);
      end
      tick();
    end
    i_reset = 1'b0; i_bus_ready = 1'b0; i_pa_rw = 1'b0; i_pb_rw = 1'b0;
    settle();
    checks++;
    if (o_bus_request !== 1'b0) begin
      errors++; $display("FAIL reset_idle_cycle: bus_request %b expected 0", o_bus_request);
    end
    tick();
    settle();
    checks++;
    if (o_bus_request !== 1'b1 || o_bus_address !== 32'hA0 || o_bus_wdata !== 32'hAAAA) begin
      errors++; $display("FAIL reset_first_grant_a: req %b addr %h wdata %h expected 1 000000a0 0000aaaa",
                         o_bus_request, o_bus_address, o_bus_wdata);
    end
    tick();
    i_pa_request = 1'b0; i_pb_request = 1'b0;
    settle();
    checks++;
    if (o_bus_request !== 1'b0) begin
      errors++; $display("FAIL reset_drop_passthrough: bus_request %b expected 0", o_bus_request);
    end
    tick();
  endtask

  task automatic test_single_a_read();
    i_pa_request = 1'b1; i_pa_rw = 1'b0; i_pa_address = 32'h0000_1000;
    tick();
    settle();
    checks++;
    if (o_bus_request !== 1'b1 || o_bus_address !== 32'h0000_1000 || o_bus_rw !== 1'b0 || o_pa_ready !== 1'b0) begin
      errors++; $display("FAIL single_read_owned1: req %b addr %h rw %b ready %b expected 1 00001000 0 0",
                         o_bus_request, o_bus_address, o_bus_rw, o_pa_ready);
    end
    tick();
    tick();
    i_bus_ready = 1'b1; i_bus_rdata = 32'hDEAD_BEEF;
    settle();
    checks++;
    if (o_pa_ready !== 1'b1 || o_pa_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL single_read_ready: ready %b rdata %h expected 1 deadbeef", o_pa_ready, o_pa_rdata);
    end
    checks++;
    if (o_pb_ready !== 1'b0 || o_pb_rdata !== 32'd0) begin
      errors++; $display("FAIL single_read_b_quiet: ready %b rdata %h expected 0 0", o_pb_ready, o_pb_rdata);
    end
    tick();
    i_pa_request = 1'b0; i_bus_ready = 1'b0;
    settle();
    checks++;
    if (o_bus_request !== 1'b0) begin
      errors++; $display("FAIL single_read_drop: bus_request %b expected 0", o_bus_request);
    end
    tick();
  endtask

  task automatic test_round_robin();
    i_pa_request = 1'b1; i_pa_address = 32'h3000; i_pa_rw = 1'b0;
    i_pb_request = 1'b1; i_pb_address = 32'h3004; i_pb_rw = 1'b0;
    settle();
    checks++;
    if (o_bus_request !== 1'b0) begin
      errors++; $display("FAIL tie_idle_cycle: bus_request %b expected 0", o_bus_request);
    end
    tick();
    i_bus_ready = 1'b1; i_bus_rdata = 32'h1234;
    settle();
    checks++;
    if (o_bus_address !== 32'h3004 || o_pb_ready !== 1'b1 || o_pb_rdata !== 32'h1234 || o_pa_ready !== 1'b0) begin
      errors++; $display("FAIL tie_grants_b: addr %h pb_ready %b pb_rdata %h pa_ready %b expected 00003004 1 00001234 0",
                         o_bus_address, o_pb_ready, o_pb_rdata, o_pa_ready);
    end
    tick();
  endtask

  task automatic test_owner_drop();
    i_pb_request = 1'b0; i_bus_ready = 1'b0;
    settle();
    checks++;
    if (o_bus_request !== 1'b0 || o_pb_ready !== 1'b0) begin
      errors++; $display("FAIL drop_passthrough: req %b pb_ready %b expected 0 0", o_bus_request, o_pb_ready);
    end
    tick();
    settle();
    checks++;
    if (o_bus_request !== 1'b0 || o_pa_ready !== 1'b0) begin
      errors++; $display("FAIL drop_idle_cycle: req %b pa_ready %b expected 0 0", o_bus_request, o_pa_ready);
    end
    tick();
    settle();
    checks++;
    if (o_bus_request !== 1'b1 || o_bus_address !== 32'h3000) begin
      errors++; $display("FAIL drop_grants_a: req %b addr %h expected 1 00003000", o_bus_request, o_bus_address);
    end
    tick();
  endtask

  task automatic test_contention();
    i_pb_request = 1'b1; i_pb_rw = 1'b1; i_pb_address = 32'h4; i_pb_wdata = 32'h55;
    i_bus_ready = 1'b1; i_bus_rdata = 32'h11;
    settle();
    checks++;
    if (o_bus_address !== 32'h3000 || o_pa_ready !== 1'b1 || o_pa_rdata !== 32'h11 || o_pb_ready !== 1'b0) begin
      errors++; $display("FAIL burst_first: addr %h pa_ready %b pa_rdata %h pb_ready %b expected 00003000 1 00000011 0",
                         o_bus_address, o_pa_ready, o_pa_rdata, o_pb_ready);
    end
    tick();
    i_pa_address = 32'h3010; i_bus_rdata = 32'h22;
    settle();
    checks++;
    if (o_bus_request !== 1'b1 || o_bus_address !== 32'h3010 || o_pa_ready !== 1'b1 || o_pa_rdata !== 32'h22) begin
      errors++; $display("FAIL burst_second: req %b addr %h pa_ready %b pa_rdata %h expected 1 00003010 1 00000022",
                         o_bus_request, o_bus_address, o_pa_ready, o_pa_rdata);
    end
    tick();
    settle();
    checks++;
    if (o_bus_request !== 1'b0 || o_pa_ready !== 1'b0 || o_pb_ready !== 1'b0 || o_bus_address !== 32'd0) begin
      errors++; $display("FAIL switch_cycle: req %b pa_ready %b pb_ready %b addr %h expected 0 0 0 0",
                         o_bus_request, o_pa_ready, o_pb_ready, o_bus_address);
    end
    tick();
    i_bus_ready = 1'b0;
    settle();
    checks++;
    if (o_bus_request !== 1'b1 || o_bus_rw !== 1'b1 || o_bus_address !== 32'h4 || o_bus_wdata !== 32'h55) begin
      errors++; $display("FAIL switch_to_b_write: req %b rw %b addr %h wdata %h expected 1 1 00000004 00000055",
                         o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata);
    end
    tick();
  endtask

  task automatic test_reset_mid_write();
    i_reset = 1'b1;
    settle();
    checks++;
    if (o_bus_request !== 1'b0 || o_bus_rw !== 1'b0 || o_bus_address !== 32'd0 || o_bus_wdata !== 32'd0) begin
      errors++; $display("FAIL midreset_outputs: req %b rw %b addr %h wdata %h expected 0 0 0 0",
                         o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata);
    end
    tick();
    i_reset = 1'b0; i_pa_request = 1'b0;
    settle();
    checks++;
    if (o_bus_request !== 1'b0) begin
      errors++; $display("FAIL midreset_idle_after: bus_request %b expected 0", o_bus_request);
    end
    tick();
    settle();
    checks++;
    if (o_bus_request !== 1'b1 || o_bus_address !== 32'h4) begin
      errors++; $display("FAIL midreset_regrant_b: req %b addr %h expected 1 00000004", o_bus_request, o_bus_address);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_a_read();
    test_round_robin();
    test_owner_drop();
    test_contention();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
